// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered ALU operands, and a held result that
// stays stable until the granted port takes it.
module alu_arbiter #(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [B-1:0] req_op1_0,
  input  logic [B-1:0] req_op1_1,
  input  logic [B-1:0] req_op2_0,
  input  logic [B-1:0] req_op2_1,
  input  logic [3:0]   req_ctrl_0,
  input  logic [3:0]   req_ctrl_1,
  output logic         resp_valid_0,
  output logic         resp_valid_1,
  input  logic         resp_ready_0,
  input  logic         resp_ready_1,
  output logic [B-1:0] resp_result,
  output logic         resp_zero,
  output logic [B-1:0] alu_op1,
  output logic [B-1:0] alu_op2,
  output logic [3:0]   alu_control,
  input  logic [B-1:0] alu_result,
  input  logic         alu_zero,
  output logic         busy,
  output logic         grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last_grant;
  logic         r_grant_id;
  logic [B-1:0] r_op1;
  logic [B-1:0] r_op2;
  logic [3:0]   r_ctrl;
  logic [B-1:0] r_result;
  logic         r_zero;
  logic         w_any_valid;
  logic         w_winner;
  logic         w_accept;
  logic         w_resp_ready;

  // Winner selection: a lone requester wins; on a tie the port not granted last time wins.
  always_comb begin
    w_any_valid = req_valid_0 | req_valid_1;
    w_winner    = (req_valid_0 & req_valid_1) ? ~r_last_grant : req_valid_1;
  end

  // Only the granted port's resp_ready can close a response; the other port is ignored.
  always_comb begin
    w_resp_ready = r_grant_id ? resp_ready_1 : resp_ready_0;
  end

  // Next-state logic and request acceptance.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (w_resp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant bookkeeping and operand latch; updated only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_ctrl       <= 4'b0000;
    end else if (w_accept) begin
      r_last_grant <= w_winner;
      r_grant_id   <= w_winner;
      r_op1        <= w_winner ? req_op1_1  : req_op1_0;
      r_op2        <= w_winner ? req_op2_1  : req_op2_0;
      r_ctrl       <= w_winner ? req_ctrl_1 : req_ctrl_0;
    end
  end

  // Result capture at the end of the EXEC cycle; held through RESP and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result <= alu_result;
      r_zero   <= alu_zero;
    end
  end

  // Output drive: handshakes are decoded from state, data straight from registers.
  always_comb begin
    req_ready_0  = w_accept & ~w_winner;
    req_ready_1  = w_accept &  w_winner;
    resp_valid_0 = (r_state == RESP) & ~r_grant_id;
    resp_valid_1 = (r_state == RESP) &  r_grant_id;
    resp_result  = r_result;
    resp_zero    = r_zero;
    alu_op1      = r_op1;
    alu_op2      = r_op2;
    alu_control  = r_ctrl;
    busy         = (r_state != IDLE);
    grant_id     = r_grant_id;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic,
// with a behavioural ALU, a transaction-level arbitration model and a
// response scoreboard checked by an independent monitor.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
  logic [3:0]  req_ctrl_0, req_ctrl_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0, resp_ready_1;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [31:0] alu_op1, alu_op2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy, grant_id;

  // Requester-side stimulus state, one entry per port.
  logic        v [2];
  logic [31:0] op1 [2];
  logic [31:0] op2 [2];
  logic [3:0]  ctl [2];
  logic        rr [2];

  assign req_valid_0  = v[0];
  assign req_valid_1  = v[1];
  assign req_op1_0    = op1[0];
  assign req_op1_1    = op1[1];
  assign req_op2_0    = op2[0];
  assign req_op2_1    = op2[1];
  assign req_ctrl_0   = ctl[0];
  assign req_ctrl_1   = ctl[1];
  assign resp_ready_0 = rr[0];
  assign resp_ready_1 = rr[1];

  alu_arbiter #(.B(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
    .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {zero, result}.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[10:6];
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = 32'($signed(a) >>> sh);
      4'd8:    r = {31'b0, ($signed(a) < $signed(b))};
      4'd9:    r = {31'b0, (a < b)};
      4'd10:   r = ~(a | b);
      4'd11:   r = a;
      4'd12:   r = b;
      4'd13:   r = {b[15:0], 16'h0000};
      default: r = 32'hFFFF_FFFF;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result} = alu_fn(alu_op1, alu_op2, alu_control);

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the arbiter: 0 = free, 1 = computing, 2 = holding result.
  int          m_state;
  logic        m_last;
  logic        m_port;
  logic [31:0] m_op1, m_op2;
  logic [3:0]  m_ctl;
  logic        acc [2];
  logic        done [2];
  logic [31:0] cap_res [2];
  logic        cap_z [2];

  task automatic model_reset();
    m_state = 0;
    m_last  = 1'b1;
    m_port  = 1'b0;
    m_op1   = 32'd0;
    m_op2   = 32'd0;
    m_ctl   = 4'd0;
    sbq.delete();
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    logic w;
    exp_t e;
    acc[0] = 1'b0; acc[1] = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;
    @(negedge clk);
    chk1("busy", busy, (m_state != 0));
    chk1("grant_id", grant_id, m_port);
    chk32("alu_op1", alu_op1, m_op1);
    chk32("alu_op2", alu_op2, m_op2);
    chk32("alu_control", 32'(alu_control), 32'(m_ctl));
    case (m_state)
      0: begin
        if (v[0] || v[1]) begin
          w = (v[0] && v[1]) ? ~m_last : v[1];
          chk1("req_ready_0", req_ready_0, ~w);
          chk1("req_ready_1", req_ready_1, w);
          e.port = w;
          {e.z, e.res} = alu_fn(op1[w], op2[w], ctl[w]);
          sbq.push_back(e);
          m_last  = w;
          m_port  = w;
          m_op1   = op1[w];
          m_op2   = op2[w];
          m_ctl   = ctl[w];
          acc[w]  = 1'b1;
          m_state = 1;
        end else begin
          chk32("req_ready_idle", 32'({req_ready_1, req_ready_0}), 32'd0);
        end
      end
      1: begin
        chk32("req_ready_exec", 32'({req_ready_1, req_ready_0}), 32'd0);
        chk32("resp_valid_exec", 32'({resp_valid_1, resp_valid_0}), 32'd0);
        m_state = 2;
      end
      default: begin
        chk32("req_ready_resp", 32'({req_ready_1, req_ready_0}), 32'd0);
        chk32("resp_valid_resp", 32'({resp_valid_1, resp_valid_0}),
              m_port ? 32'd2 : 32'd1);
        if (rr[m_port]) begin
          cap_res[m_port] = resp_result;
          cap_z[m_port]   = resp_zero;
          done[m_port]    = 1'b1;
          m_state         = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    if (acc[0]) v[0] = 1'b0;
    if (acc[1]) v[1] = 1'b0;
  endtask

  task automatic req(input int p, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c);
    v[p]   = 1'b1;
    op1[p] = a;
    op2[p] = b;
    ctl[p] = c;
  endtask

  task automatic wait_done(input int p, input int max_cycles);
    int n;
    n = 0;
    while (!done[p] && n < max_cycles) begin
      step();
      n++;
    end
    chk1("response_timeout", done[p], 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk32({tag, "_req_ready"}, 32'({req_ready_1, req_ready_0}), 32'd0);
    chk32({tag, "_resp_valid"}, 32'({resp_valid_1, resp_valid_0}), 32'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_grant_id"}, grant_id, 1'b0);
    chk32({tag, "_resp_result"}, resp_result, 32'd0);
    chk1({tag, "_resp_zero"}, resp_zero, 1'b0);
    chk32({tag, "_alu_op1"}, alu_op1, 32'd0);
    chk32({tag, "_alu_op2"}, alu_op2, 32'd0);
    chk32({tag, "_alu_control"}, 32'(alu_control), 32'd0);
  endtask

  // Response monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (resp_valid_0 || resp_valid_1)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=valid expected=none at %0t", $time);
      end else begin
        chk1("mon_port", resp_valid_1, sbq[0].port);
        chk32("mon_result", resp_result, sbq[0].res);
        chk1("mon_zero", resp_zero, sbq[0].z);
        if (resp_valid_1 ? resp_ready_1 : resp_ready_0) begin
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hold;
    logic [31:0] a, b;
    v[0] = 1'b0; v[1] = 1'b0;
    rr[0] = 1'b0; rr[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      op1[p] = 32'd0; op2[p] = 32'd0; ctl[p] = 4'd0;
      cap_res[p] = 32'd0; cap_z[p] = 1'b0;
    end
    model_reset();
    rst_n = 1'b0;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD on port 0: accepted the same cycle, response two cycles later.
    req(0, 32'd5, 32'd7, 4'd0);
    rr[0] = 1'b1;
    step();
    chk1("add_accept_same_cycle", acc[0], 1'b1);
    step();
    step();
    chk1("add_resp_at_n_plus_2", done[0], 1'b1);
    chk32("add_result", cap_res[0], 32'd12);
    chk1("add_zero", cap_z[0], 1'b0);

    // Zero flag via SUB on port 1.
    req(1, 32'h1234, 32'h1234, 4'd1);
    rr[1] = 1'b1;
    wait_done(1, 6);
    chk32("sub_result", cap_res[1], 32'd0);
    chk1("sub_zero", cap_z[1], 1'b1);

    // Tie: port 0 first, loser granted right after, then port 0 again.
    req(0, 32'd1, 32'd1, 4'd0);
    req(1, 32'hF0, 32'h0F, 4'd3);
    step();
    chk1("tie_first_port0", acc[0], 1'b1);
    step();
    step();
    step();
    chk1("tie_loser_next", acc[1], 1'b1);
    wait_done(1, 4);
    chk32("tie_add_result", cap_res[0], 32'd2);
    chk32("tie_or_result", cap_res[1], 32'hFF);
    req(0, 32'd3, 32'd4, 4'd0);
    req(1, 32'd8, 32'd9, 4'd0);
    step();
    chk1("rerequest_port0", acc[0], 1'b1);
    wait_done(0, 4);
    wait_done(1, 6);

    // Backpressure on port 0 while port 1 waits.
    rr[0] = 1'b0;
    req(0, 32'h1111_0000, 32'h0000_2222, 4'd0);
    step();
    req(1, 32'h00FF_00FF, 32'h0F0F_0F0F, 4'd4);
    rr[1] = 1'b1;
    step();
    hold = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_resp_valid_0", resp_valid_0, 1'b1);
      chk32("bp_result_stable", resp_result, hold);
      chk1("bp_busy", busy, 1'b1);
      chk1("bp_req_ready_1", req_ready_1, 1'b0);
    end
    rr[0] = 1'b1;
    step();
    chk1("bp_handshake", done[0], 1'b1);
    step();
    chk1("bp_port1_next_cycle", acc[1], 1'b1);
    wait_done(1, 4);
    chk32("bp_port1_result", cap_res[1], 32'h0FF0_0FF0);

    // Shift, LUI and unchecked opcodes are passed through.
    req(0, 32'd1, 32'd4 << 6, 4'd5);
    wait_done(0, 6);
    chk32("sll_result", cap_res[0], 32'd16);
    req(1, 32'd0, 32'h0000_ABCD, 4'd13);
    wait_done(1, 6);
    chk32("lui_result", cap_res[1], 32'hABCD_0000);
    req(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd15);
    wait_done(0, 6);
    chk32("op15_result", cap_res[0], 32'hFFFF_FFFF);

    // Asynchronous reset while in EXEC.
    req(1, 32'd40, 32'd2, 4'd0);
    step();
    rst_n = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
    rr[0] = 1'b0; rr[1] = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step();
    req(0, 32'd100, 32'd23, 4'd0);
    req(1, 32'd6, 32'd6, 4'd2);
    rr[0] = 1'b1; rr[1] = 1'b1;
    step();
    chk1("post_reset_tie_port0", acc[0], 1'b1);
    wait_done(0, 4);
    chk32("post_reset_result", cap_res[0], 32'd123);
    wait_done(1, 6);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && ($urandom_range(0, 2) == 0)) begin
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : $urandom;
          req(p, a, b, 4'($urandom_range(0, 15)));
        end
        rr[p] = 1'($urandom_range(0, 1));
      end
      step();
    end
    v[0] = 1'b0; v[1] = 1'b0;
    rr[0] = 1'b1; rr[1] = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk32("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execution-stage ALU between two requesters: port 0 (pipeline execute path) and port 1 (debug/self-test unit). Each port uses a valid/ready request channel and a valid/ready response channel. The arbiter grants round-robin, drives the ALU from registered operands, captures the result and zero flag, and holds them until the granted port accepts them. The ALU itself stays purely combinational; this block supplies all sequencing.

## Interface

Parameters:
- B, 32, datapath width of operands and result.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_0 / req_valid_1  in  1  request present on port 0 / port 1.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_op1_0 / req_op1_1  in  B  first operand.
- req_op2_0 / req_op2_1  in  B  second operand. Shift-amount field is bits [10:6] for SLL/SRL/SRA.
- req_ctrl_0 / req_ctrl_1  in  4  ALU operation code (0000 ADD … 1101 LUI).
- resp_valid_0 / resp_valid_1  out  1  result available for that port.
- resp_ready_0 / resp_ready_1  in  1  port consumes the result.
- resp_result  out  B  captured ALU result, shared by both ports.
- resp_zero  out  1  captured zero flag.
- alu_op1, alu_op2  out  B  operands driven to the ALU.
- alu_control  out  4  operation code driven to the ALU.
- alu_result  in  B  ALU result.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  port currently owning the ALU. Valid while busy.

## Operation

- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid_x is high, select a winner. A single requester wins outright. If both are valid, the port not granted last time wins (last_grant register).
  - Assert req_ready_x combinationally for the winner only.
  - On the clock edge: latch op1, op2 and ctrl into internal registers, set grant_id and last_grant to the winner, and move to EXEC.
- **EXEC**
  - alu_op1, alu_op2 and alu_control are driven from the latched registers.
  - On the clock edge: capture alu_result into resp_result and alu_zero into resp_zero, then move to RESP.
- **RESP**
  - resp_valid_{grant_id} is high. The other port's resp_valid is low.
  - resp_result and resp_zero stay stable.
  - When resp_ready_{grant_id} is high, return to IDLE on that clock edge. Otherwise stay in RESP indefinitely.
- req_ready_x is low in EXEC and RESP. Requests arriving then wait. Requesters must keep valid and operands stable until ready is seen.
- The ALU drive registers (alu_op1, alu_op2, alu_control) hold their last latched values outside EXEC. They only change on an IDLE grant.
- Opcodes 1110 and 1111 are passed through unchecked. The arbiter returns whatever the ALU produces (all ones).
- Width rule: no arithmetic inside the arbiter. Data is moved bit-exact, B bits wide.
- Out-of-state resp_ready is ignored. This covers resp_ready while not in RESP, and resp_ready from the non-granted port.

## Timing

- Reset values:
  - State = IDLE.
  - last_grant = 1, so port 0 wins the first tie.
  - grant_id = 0, busy = 0.
  - All req_ready and resp_valid = 0.
  - resp_result = 0, resp_zero = 0.
  - alu_op1 = 0, alu_op2 = 0, alu_control = 0000.
- Latency: request accepted at edge N; ALU driven during cycle N+1; resp_valid high from cycle N+2.
- Minimum occupancy is 3 cycles per operation. The earliest next accept is the cycle after the response handshake edge.
- Simultaneous valid on both ports in IDLE: exactly one req_ready is asserted. The loser is granted next, provided it is still valid, even if the winner re-requests.
- Asynchronous reset mid-operation (EXEC or RESP):
  - All outputs go to their reset values immediately.
  - The in-flight result is discarded and no resp_valid is issued.
  - Requesters must re-issue.

## Test plan

- **Single ADD on port 0:** op1=5, op2=7, ctrl=0000 → req_ready_0 in the same cycle; resp_valid_0 two cycles later with resp_result=12, resp_zero=0.
- **Zero flag on port 1:** SUB with op1=op2=0x1234 → resp_result=0, resp_zero=1, resp_valid_1 high, resp_valid_0 low.
- **Tie after reset, then alternation:**
  - Both ports valid after reset → port 0 granted first (ADD 1+1=2), then port 1 (OR 0xF0|0x0F=0xFF).
  - Both re-request → port 0 again.
- **Backpressure:** hold resp_ready_0 low for 5 cycles → resp_valid_0 and resp_result stable throughout, busy=1, req_ready_1 stays low for a pending port-1 request. Release → IDLE, then port 1 is accepted the next cycle.
- **Shift and LUI passthrough:**
  - SLL with op1=1, op2[10:6]=4 → result 16.
  - LUI with op2=0xABCD → result 0xABCD0000.
  - ctrl=1111 → result 0xFFFFFFFF.
- **Reset in EXEC:** drop rst_n during EXEC → all outputs return to their reset values asynchronously; no resp_valid after reset release. A new request then completes normally with last_grant reset (port 0 wins a tie).
